// File: rtl/div_defs.sv
// Shared definitions for the div2 radix-2 restoring divider.
package div_defs;
   localparam int DIV_WIDTH = 32;
   localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'b00,
      DIV_DIVZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
   parameter int WIDTH = 32
) (
   // The partial remainder's top bit is always zero before a shift, so only the low bits enter.
   input  logic [WIDTH-2:0] rem,
   input  logic             din,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_next,
   output logic             q_bit
);
   logic [WIDTH-1:0] shifted;
   logic [WIDTH:0]   trial;

   always_comb begin
      shifted  = {rem, din};
      trial    = {1'b0, shifted} - {1'b0, divisor};
      q_bit    = ~trial[WIDTH];
      rem_next = q_bit ? trial[WIDTH-1:0] : shifted;
   end
endmodule

// File: rtl/div2.sv
// Multi-cycle signed/unsigned integer divider; one quotient bit per cycle on magnitudes,
// sign fix-up at the end. result_o = {remainder, quotient}.
module div2
   import div_defs::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               signed_div_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               start_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o,
   output logic               div_stall
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_t       state, next_state;
   logic             sign_a, sign_b, sgn, dz;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] dvd;      // dividend magnitude; quotient bits shift in from the bottom
   logic [WIDTH-1:0] rem;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] step_rem;
   logic             q_bit;
   logic [WIDTH-1:0] rem_fix, quo_fix;

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem      (rem[WIDTH-2:0]),
      .din      (dvd[WIDTH-1]),
      .divisor  (divisor),
      .rem_next (step_rem),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= DIV_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         DIV_IDLE:    if (start_i && !annul_i)
                         next_state = (opdata2_i == '0) ? DIV_DIVZERO : DIV_ON;
         DIV_DIVZERO: next_state = annul_i ? DIV_IDLE : DIV_END;
         DIV_ON:      if (annul_i) next_state = DIV_IDLE;
                      else if (count == CNT_W'(WIDTH - 1)) next_state = DIV_END;
         DIV_END:     next_state = DIV_IDLE;
         default:     next_state = DIV_IDLE;
      endcase
   end

   // Divide-by-zero results bypass the sign fix-up.
   always_comb begin
      rem_fix = (!dz && sgn && sign_a)            ? -rem : rem;
      quo_fix = (!dz && sgn && (sign_a ^ sign_b)) ? -dvd : dvd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         sgn       <= 1'b0;
         dz        <= 1'b0;
         divisor   <= '0;
         dvd       <= '0;
         rem       <= '0;
         count     <= '0;
         result_o  <= '0;
         ready_o   <= 1'b0;
         div_stall <= 1'b0;
      end else begin
         ready_o <= 1'b0;
         case (state)
            DIV_IDLE: if (start_i && !annul_i) begin
               sign_a    <= opdata1_i[WIDTH-1];
               sign_b    <= opdata2_i[WIDTH-1];
               sgn       <= signed_div_i;
               dvd       <= (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
               divisor   <= (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
               rem       <= '0;
               count     <= '0;
               dz        <= 1'b0;
               div_stall <= 1'b1;
            end
            DIV_ON: if (annul_i) begin
               div_stall <= 1'b0;
            end else begin
               rem   <= step_rem;
               dvd   <= {dvd[WIDTH-2:0], q_bit};
               count <= count + 1'b1;
            end
            DIV_DIVZERO: if (annul_i) begin
               div_stall <= 1'b0;
            end else begin
               // Re-negating the magnitude recovers the raw dividend exactly.
               rem <= (sgn && sign_a) ? -dvd : dvd;
               dvd <= '1;
               dz  <= 1'b1;
            end
            DIV_END: begin
               div_stall <= 1'b0;
               if (!annul_i) begin
                  result_o <= {rem_fix, quo_fix};
                  ready_o  <= 1'b1;
               end
            end
            default: div_stall <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_div2.sv
// Self-checking bench for div2: directed corner cases, random operands against a
// plain-arithmetic reference, annul, async reset and back-to-back starts.
module tb_div2;
   logic        clk = 1'b0;
   logic        rst;
   logic        signed_div_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic        start_i, annul_i;
   logic [63:0] result_o;
   logic        ready_o, div_stall;

   int total = 0;
   int bad   = 0;

   div2 dut (
      .clk          (clk),
      .rst          (rst),
      .signed_div_i (signed_div_i),
      .opdata1_i    (opdata1_i),
      .opdata2_i    (opdata2_i),
      .start_i      (start_i),
      .annul_i      (annul_i),
      .result_o     (result_o),
      .ready_o      (ready_o),
      .div_stall    (div_stall)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint la, lb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (!s) return {a % b, a / b};
      la = longint'($signed(a));
      lb = longint'($signed(b));
      q  = la / lb;
      r  = la % lb;
      return {r[31:0], q[31:0]};
   endfunction

   // Issues one divide and scrambles the operands right after they are sampled.
   task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat,
                         output int stall_bad, output int pulse_bad);
      lat = -1; stall_bad = 0; pulse_bad = 0; res = '0;
      @(negedge clk);
      signed_div_i = s; opdata1_i = a; opdata2_i = b; start_i = 1'b1;
      @(posedge clk); #1;
      if (div_stall !== 1'b1) stall_bad++;
      @(negedge clk);
      start_i = 1'b0; signed_div_i = ~s; opdata1_i = $urandom; opdata2_i = $urandom;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (ready_o === 1'b1) begin
            lat = n; res = result_o;
            if (div_stall !== 1'b0) stall_bad++;
            break;
         end
         if (div_stall !== 1'b1) stall_bad++;
      end
      @(posedge clk); #1;
      if (ready_o !== 1'b0) pulse_bad++;
   endtask

   task automatic check_op(input string name, input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] res, exp;
      int lat, sb, pb, exp_lat;
      exp     = ref_div(s, a, b);
      exp_lat = (b == 32'd0) ? 2 : 33;
      do_div(s, a, b, res, lat, sb, pb);
      total++;
      if (res !== exp) begin
         bad++;
         $display("FAIL %s result s=%0d a=%h b=%h got=%h want=%h", name, s, a, b, res, exp);
      end
      total++;
      if (lat !== exp_lat) begin
         bad++;
         $display("FAIL %s latency got=%0d want=%0d", name, lat, exp_lat);
      end
      total++;
      if (sb !== 0 || pb !== 0) begin
         bad++;
         $display("FAIL %s handshake stall_errs=%0d pulse_errs=%0d want 0/0", name, sb, pb);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
      signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (result_o !== 64'd0 || ready_o !== 1'b0 || div_stall !== 1'b0) begin
         bad++;
         $display("FAIL reset result=%h ready=%b stall=%b want 0/0/0", result_o, ready_o, div_stall);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_directed();
      check_op("u100_7",      1'b0, 32'd100,        32'd7);
      check_op("s_m7_2",      1'b1, 32'hFFFF_FFF9,  32'd2);
      check_op("s_7_m2",      1'b1, 32'd7,          32'hFFFF_FFFE);
      check_op("s_ovf",       1'b1, 32'h8000_0000,  32'hFFFF_FFFF);
      check_op("u_max_1",     1'b0, 32'hFFFF_FFFF,  32'd1);
      check_op("divzero",     1'b0, 32'h1234_5678,  32'd0);
      check_op("s_divzero",   1'b1, 32'h8765_4321,  32'd0);
      check_op("u_big_dvsr",  1'b0, 32'hFFFF_FFFE,  32'hFFFF_FFFF);
      check_op("u_hi_dvsr",   1'b0, 32'hFFFF_FFFF,  32'h8000_0001);
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      logic s;
      for (int i = 0; i < 24; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0: b = $urandom;
            1: b = $urandom_range(1, 255);
            2: b = -$urandom_range(1, 255);
            default: b = (i % 8 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
         endcase
         check_op("random", s, a, b);
      end
   endtask

   task automatic test_annul();
      logic [63:0] prev;
      int ready_seen = 0;
      prev = result_o;
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd5000; opdata2_i = 32'd3; start_i = 1'b1;
      @(posedge clk);
      @(negedge clk); start_i = 1'b0;
      repeat (8) @(posedge clk);
      @(negedge clk); annul_i = 1'b1;
      @(posedge clk); #1;
      total++;
      if (div_stall !== 1'b0) begin
         bad++;
         $display("FAIL annul_stall got=%b want=0", div_stall);
      end
      @(negedge clk); annul_i = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (ready_o === 1'b1) ready_seen++;
      end
      total++;
      if (ready_seen !== 0 || result_o !== prev) begin
         bad++;
         $display("FAIL annul_quiet ready_pulses=%0d result=%h want 0 pulses, result=%h", ready_seen, result_o, prev);
      end
      check_op("after_annul", 1'b1, 32'hFFFF_D8F0, 32'd77);
   endtask

   task automatic test_async_reset();
      int ready_seen = 0;
      @(negedge clk);
      signed_div_i = 1'b1; opdata1_i = 32'h7654_3210; opdata2_i = 32'd13; start_i = 1'b1;
      @(posedge clk);
      @(negedge clk); start_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd4;
      repeat (14) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      total++;
      if (result_o !== 64'd0 || ready_o !== 1'b0 || div_stall !== 1'b0) begin
         bad++;
         $display("FAIL async_rst result=%h ready=%b stall=%b want 0/0/0", result_o, ready_o, div_stall);
      end
      #1 rst = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (ready_o === 1'b1 || div_stall === 1'b1) ready_seen++;
      end
      total++;
      if (ready_seen !== 0) begin
         bad++;
         $display("FAIL async_rst_idle busy_or_ready_cycles=%0d want 0", ready_seen);
      end
      check_op("after_rst", 1'b1, 32'h8000_0001, 32'd3);
   endtask

   task automatic test_back_to_back();
      logic [63:0] exp1, exp2;
      logic [63:0] res_q[$];
      int          edge_q[$];
      int          stall_bad = 0;
      exp1 = ref_div(1'b0, 32'd1000, 32'd9);
      exp2 = ref_div(1'b1, 32'hFFFF_FC18, 32'd7);
      @(negedge clk);
      signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd9; start_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FC18; opdata2_i = 32'd7;
      for (int n = 1; n <= 70; n++) begin
         @(posedge clk); #1;
         if (ready_o === 1'b1) begin
            edge_q.push_back(n);
            res_q.push_back(result_o);
         end
         if (n == 34 && div_stall !== 1'b1) stall_bad++;
         if (n == 34) begin
            @(negedge clk); start_i = 1'b0;
         end
      end
      total++;
      if (edge_q.size() !== 2) begin
         bad++;
         $display("FAIL b2b_pulses got=%0d want=2", edge_q.size());
      end else begin
         total++;
         if (edge_q[0] !== 33 || edge_q[1] !== 67) begin
            bad++;
            $display("FAIL b2b_timing got=%0d,%0d want=33,67", edge_q[0], edge_q[1]);
         end
         total++;
         if (res_q[0] !== exp1 || res_q[1] !== exp2) begin
            bad++;
            $display("FAIL b2b_results got=%h,%h want=%h,%h", res_q[0], res_q[1], exp1, exp2);
         end
      end
      total++;
      if (stall_bad !== 0) begin
         bad++;
         $display("FAIL b2b_restart_stall got=%0d want=0", stall_bad);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_annul();
      test_async_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/div2.md
Name: div2

Overview:
- Multi-cycle 32-bit integer divider for the EX stage; the inverse companion of the mul2 multiplier.
- Shares mul2's start/ready/stall handshake, so the EX-stage mul/div control can drive both blocks identically.
- Produces remainder (HI) and quotient (LO) for DIV/DIVU.
- Radix-2 restoring algorithm, one quotient bit per cycle, on magnitudes with a final sign fix-up.

Parameters:
- WIDTH, 32, operand width; sets the iteration count and the result width (2*WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state and outputs.
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); latched at start.
- opdata1_i  in  WIDTH  dividend; latched at start.
- opdata2_i  in  WIDTH  divisor; latched at start.
- start_i  in  1  request; sampled only in IDLE.
- annul_i  in  1  flush (exception or branch); aborts the operation in progress.
- result_o  out  2*WIDTH  {remainder, quotient}; [63:32] = HI, [31:0] = LO.
- ready_o  out  1  one-cycle pulse; result_o is valid while it is high.
- div_stall  out  1  high while busy; EX stage holds the pipeline on it.

Behaviour:
- Reset (async): state=IDLE, result_o=0, ready_o=0, div_stall=0, count=0, datapath registers=0.
  - Reset asserted mid-operation aborts immediately; no ready pulse follows.
- States (2-bit): IDLE, DIVZERO, ON, END.
- IDLE:
  - ready_o<=0.
  - On start_i=1 and annul_i=0:
    - Latch sign_a, sign_b and signed flag.
    - Latch abs values; two's-complement negate only when signed and the sign bit is set.
    - div_stall<=1.
    - If divisor==0: go to DIVZERO.
    - Otherwise: partial remainder<=0, count<=0, go to ON.
  - start_i with annul_i=1 is ignored.
- ON, each cycle:
  - trial = {rem[WIDTH-2:0], dividend_msb} - divisor, computed in WIDTH+1 bits.
  - If non-negative: rem<=trial, shift in quotient bit 1; else restore and shift in 0.
  - count++. When count reaches WIDTH-1 in this step, go to END.
- DIVZERO:
  - Internal quotient<=all ones, remainder<=raw latched dividend, no sign fix.
  - Go to END.
- END:
  - Quotient is negated if signed and sign_a^sign_b.
  - Remainder is negated if signed and sign_a (remainder takes the dividend's sign).
  - result_o<=fixed result, ready_o<=1, div_stall<=0, go to IDLE.
- Latency with start sampled at edge E0:
  - Normal divide: ready_o is high from E(WIDTH+1) to E(WIDTH+2), i.e. E33–E34.
  - Divide by zero: ready_o is high E2–E3.
  - div_stall is high from E0 until the same edge that raises ready_o.
- annul_i = 1 in ON, DIVZERO or END:
  - Go to IDLE, div_stall<=0, ready_o stays 0, result_o keeps its old value.
  - annul_i has priority over the END transition.
- start_i outside IDLE is ignored, including back-to-back start in the ready cycle.
  - A new start is accepted in the IDLE cycle after ready_o.
- Input operands may change after E0 without effect; this differs from mul2, which reads its inputs live.
- Signed overflow 0x80000000 / 0xFFFFFFFF: result is quotient 0x80000000, remainder 0, no trap.
- result_o holds the last value until the next END or reset.

Decomposition:
- Shared package div_defs:
  - State encodings DIV_IDLE=2'b00, DIV_DIVZERO=2'b01, DIV_ON=2'b10, DIV_END=2'b11.
  - DIV_WIDTH=32 and the count width.
- Optional combinational sub-module div_step:
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: new remainder and quotient bit.
  - Isolates the subtract/restore step for unit test.

Test Plan:
- Unsigned 100 / 7 (signed_div_i=0), start at E0:
  - result_o = {0x00000002, 0x0000000E}.
  - ready_o high exactly at E33.
  - div_stall high E0–E33.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002):
  - Quotient 0xFFFFFFFD, remainder 0xFFFFFFFF.
- Signed 7 / -2:
  - Quotient 0xFFFFFFFD, remainder 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF:
  - Quotient 0x80000000, remainder 0.
- Unsigned 0xFFFFFFFF / 1:
  - Quotient 0xFFFFFFFF, remainder 0.
- Divide by zero, 0x12345678 / 0:
  - Result {0x12345678, 0xFFFFFFFF}; ready_o at E2; no ON cycles.
- annul_i at E10 mid-divide:
  - Returns to IDLE, div_stall low, no ready pulse, result_o unchanged.
  - A following start computes correctly.
- Async rst pulse between clock edges at E15:
  - All outputs 0 immediately, state IDLE.
  - Operands changed after E0 do not affect a fresh run.
